mem_access_ctrl: RTL and testbench

Sequencer for the MEM stage of the five-stage pipeline. It takes the memory-control field, ALU result (address) and rs2 data registered in the EX/MEM pipeline register, and runs one load or store per instruction on a single-outstanding req/gnt/rvalid data-memory port. It aligns and extends load data, builds store byte strobes, and drives a pipeline stall until the access completes. Misaligned accesses and response timeouts are flagged as exceptions.

---
 rtl/mem_access_ctrl_if.sv | 25 ++
 rtl/mem_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Data-memory port bundle between the MEM-stage sequencer and data memory.
// master: drives req/we/addr/wdata/wstrb, receives gnt/rvalid/rdata.
// slave : the memory side of the same single-outstanding req/gnt/rvalid port.
interface mem_access_ctrl_if #(
  parameter int REG_WIDTH = 64
);
  logic                 mem_req;
  logic                 mem_we;
  logic [REG_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0] mem_wdata;
  logic [7:0]           mem_wstrb;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [REG_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one load/store per instruction over a req/gnt/rvalid port.
// Ports: clk/rst; M_Ctrl_in/addr_in/wdata_in from EX/MEM; stall, load_data,
//        load_valid, misalign, bus_err to the pipeline; mem (master) to data memory.
module mem_access_ctrl #(
  parameter int REG_WIDTH   = 64,
  parameter int M_Ctrl_bits = 5,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [M_Ctrl_bits-1:0] M_Ctrl_in,
  input  logic [REG_WIDTH-1:0]   addr_in,
  input  logic [REG_WIDTH-1:0]   wdata_in,
  output logic                   stall,
  output logic [REG_WIDTH-1:0]   load_data,
  output logic                   load_valid,
  output logic                   misalign,
  output logic                   bus_err,
  mem_access_ctrl_if.master      mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Last WAIT-cycle count value before the access is declared dead.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t state, state_nxt;

  logic       rd, wr, uns;
  logic [1:0] size;
  logic [2:0] lane;
  logic       op_valid;
  logic       timeout;
  logic [7:0] strb;

  logic [1:0] size_q;
  logic       uns_q;
  logic [2:0] lane_q;
  logic       err_q;
  logic [7:0] cnt;

  logic [REG_WIDTH-1:0] shifted;
  logic [REG_WIDTH-1:0] ext;

  assign rd   = M_Ctrl_in[0];
  assign wr   = M_Ctrl_in[1];
  assign size = M_Ctrl_in[3:2];
  assign uns  = M_Ctrl_in[4];
  assign lane = addr_in[2:0];

  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b01:   misalign = lane[0];
      2'b10:   misalign = |lane[1:0];
      2'b11:   misalign = |lane;
      default: misalign = 1'b0;
    endcase
    misalign = misalign & (rd | wr);
  end

  assign op_valid = (rd | wr) & ~misalign;

  always_comb begin
    strb = 8'h00;
    case (size)
      2'b00:   strb = 8'h01 << lane;
      2'b01:   strb = 8'h03 << lane;
      2'b10:   strb = 8'h0F << lane;
      default: strb = 8'hFF;
    endcase
  end

  // rvalid has priority: a response landing on the last allowed cycle is good.
  assign timeout = (state == WAIT) & ~mem.mem_rvalid & (cnt == TO_LAST);

  // Load alignment and extension from the latched lane/size/unsigned fields.
  assign shifted = mem.mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    ext = shifted;
    case (size_q)
      2'b00:   ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'b01:   ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (op_valid) state_nxt = REQ;
      REQ:  if (mem.mem_gnt) state_nxt = WAIT;
      WAIT: if (mem.mem_rvalid || timeout) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    stall      = (state == REQ) | (state == WAIT) | ((state == IDLE) & op_valid);
    load_valid = (state == DONE) & ~mem.mem_we & ~err_q;
    bus_err    = (state == DONE) & err_q;
  end

  // Request-side registers, timeout counter and load capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= 8'h00;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      lane_q        <= 3'd0;
      err_q         <= 1'b0;
      cnt           <= 8'd0;
      load_data     <= '0;
    end else begin
      mem.mem_req <= (state_nxt == REQ);
      if (state == IDLE && op_valid) begin
        // Read wins when both mem_read and mem_write are set.
        mem.mem_we    <= wr & ~rd;
        mem.mem_addr  <= {addr_in[REG_WIDTH-1:3], 3'b000};
        mem.mem_wdata <= wdata_in << {lane, 3'b000};
        mem.mem_wstrb <= strb;
        size_q        <= size;
        uns_q         <= uns;
        lane_q        <= lane;
        err_q         <= 1'b0;
      end
      if (state == REQ && mem.mem_gnt) begin
        cnt <= 8'd0;
      end else if (state == WAIT && !mem.mem_rvalid) begin
        cnt <= cnt + 8'd1;
      end
      if (state == WAIT) begin
        if (mem.mem_rvalid) begin
          if (!mem.mem_we) load_data <= ext;
        end else if (timeout) begin
          load_data <= '0;
          err_q     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  M_Ctrl_in;
  logic [63:0] addr_in;
  logic [63:0] wdata_in;
  logic        stall;
  logic [63:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl_if #(.REG_WIDTH(64)) bus ();

  mem_access_ctrl #(.REG_WIDTH(64), .M_Ctrl_bits(5), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .M_Ctrl_in  (M_Ctrl_in),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gnt_at / rv_at: 1-based REQ / WAIT cycle carrying the response; rv_at=0 never responds.
  task automatic access(input string tag, input logic [4:0] ctrl, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input int gnt_at, input int rv_at, input int exp_stall,
                        input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                        input logic [7:0] exp_wstrb, input logic exp_we,
                        input logic exp_lv, input logic [63:0] exp_ld, input logic exp_err);
    int stalls = 0, reqc = 0, waitc = 0, spur = 0, unstable = 0;
    bit in_wait = 0, done = 0;
    M_Ctrl_in     = ctrl;
    addr_in       = addr;
    wdata_in      = wdata;
    bus.mem_rdata = rdata;
    for (int c = 0; c < 60 && !done; c++) begin
      bus.mem_gnt    = bus.mem_req && (reqc + 1 == gnt_at);
      bus.mem_rvalid = in_wait && (rv_at != 0) && (waitc + 1 == rv_at);
      @(negedge clk);
      if (stall) stalls++;
      if (bus.mem_req) begin
        if (reqc == 0) begin
          chk({tag, "_addr"},  bus.mem_addr,  exp_addr);
          chk({tag, "_we"},    bus.mem_we,    exp_we);
          chk({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
          chk({tag, "_wstrb"}, bus.mem_wstrb, exp_wstrb);
        end else if (bus.mem_addr !== exp_addr || bus.mem_we !== exp_we ||
                     bus.mem_wdata !== exp_wdata || bus.mem_wstrb !== exp_wstrb) begin
          unstable++;
        end
        reqc++;
      end
      if (in_wait) begin
        waitc++;
        if (bus.mem_rvalid) in_wait = 0;
      end
      if (bus.mem_req && bus.mem_gnt) in_wait = 1;
      if (c > 0 && !stall) begin
        done = 1;
        chk({tag, "_load_valid"}, load_valid, exp_lv);
        chk({tag, "_bus_err"},    bus_err,    exp_err);
        if (exp_lv || exp_err) chk({tag, "_load_data"}, load_data, exp_ld);
      end else if (load_valid || bus_err) begin
        spur++;
      end
      step();
    end
    chk({tag, "_done"},       done,     1);
    chk({tag, "_stall_cyc"},  stalls,   exp_stall);
    chk({tag, "_req_cyc"},    reqc,     gnt_at);
    chk({tag, "_req_stable"}, unstable, 0);
    chk({tag, "_spurious"},   spur,     0);
    M_Ctrl_in      = 5'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_after_pulse"}, {load_valid, bus_err, stall}, 3'b000);
    step();
  endtask

  initial begin
    int mis_cnt, st_cnt, rq_cnt;
    rst            = 1'b1;
    M_Ctrl_in      = 5'b0;
    addr_in        = 64'h0;
    wdata_in       = 64'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 64'h0;
    #12;
    chk("rst_stall",     stall,          0);
    chk("rst_req",       bus.mem_req,    0);
    chk("rst_we",        bus.mem_we,     0);
    chk("rst_addr",      bus.mem_addr,   0);
    chk("rst_wdata",     bus.mem_wdata,  0);
    chk("rst_wstrb",     bus.mem_wstrb,  0);
    chk("rst_load_data", load_data,      0);
    chk("rst_pulses",    {load_valid, bus_err}, 2'b00);
    step();
    rst = 1'b0;
    step();

    // Byte loads, signed and unsigned, lane 3.
    access("lb",  5'b00001, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, 1, 3,
           64'h1000, 64'h0, 8'h08, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    access("lbu", 5'b10001, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, 1, 3,
           64'h1000, 64'h0, 8'h08, 1'b0, 1'b1, 64'h0000_0000_0000_0080, 1'b0);
    // Half store into the top lanes.
    access("sh",  5'b00110, 64'h2006, 64'h1234, 64'h0, 1, 1, 3,
           64'h2000, 64'h1234_0000_0000_0000, 8'hC0, 1'b1, 1'b0, 64'h0, 1'b0);
    // Doubleword load with slow grant and response.
    access("ld_slow", 5'b01101, 64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 2, 6,
           64'h3000, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
    access("lh",  5'b00101, 64'h4002, 64'h0, 64'h0000_0000_8001_0000, 1, 1, 3,
           64'h4000, 64'h0, 8'h0C, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    access("lwu", 5'b11001, 64'h4004, 64'h0, 64'hF000_000A_0000_0000, 1, 1, 3,
           64'h4000, 64'h0, 8'hF0, 1'b0, 1'b1, 64'h0000_0000_F000_000A, 1'b0);
    access("lw",  5'b01001, 64'h4004, 64'h0, 64'hF000_000A_0000_0000, 1, 1, 3,
           64'h4000, 64'h0, 8'hF0, 1'b0, 1'b1, 64'hFFFF_FFFF_F000_000A, 1'b0);
    access("sw",  5'b01010, 64'h5004, 64'h0000_0000_DEAD_BEEF, 64'h0, 1, 1, 3,
           64'h5000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1, 1'b0, 64'h0, 1'b0);
    // Read and write both set: performed as a read.
    access("rdwr", 5'b00011, 64'h5005, 64'h11, 64'h0000_7F00_0000_0000, 1, 1, 3,
           64'h5000, 64'h0000_1100_0000_0000, 8'h20, 1'b0, 1'b1, 64'h7F, 1'b0);
    // No response: timeout after the 4th WAIT cycle.
    access("tmo", 5'b01101, 64'h6000, 64'h0, 64'h0, 1, 0, 6,
           64'h6000, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b1);
    // Response on the last allowed WAIT cycle wins over the timeout.
    access("rv_last", 5'b01101, 64'h6008, 64'h0, 64'h5555_AAAA_5555_AAAA, 1, 4, 6,
           64'h6008, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h5555_AAAA_5555_AAAA, 1'b0);

    // Misaligned word: no request, no stall, over several cycles.
    M_Ctrl_in = 5'b01001;
    addr_in   = 64'h1002;
    mis_cnt = 0; st_cnt = 0; rq_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (misalign) mis_cnt++;
      if (stall) st_cnt++;
      if (bus.mem_req || load_valid || bus_err) rq_cnt++;
      step();
    end
    chk("lw_mis_flag",  mis_cnt, 4);
    chk("lw_mis_stall", st_cnt,  0);
    chk("lw_mis_req",   rq_cnt,  0);
    M_Ctrl_in = 5'b00101; addr_in = 64'h1001;   // LH odd
    #1 chk("lh_mis", {misalign, stall}, 2'b10);
    M_Ctrl_in = 5'b01110; addr_in = 64'h3004;   // SD not 8-aligned
    #1 chk("sd_mis", {misalign, stall}, 2'b10);
    M_Ctrl_in = 5'b01100; addr_in = 64'h0007;   // no access
    #1 chk("nop", {misalign, stall}, 2'b00);
    M_Ctrl_in = 5'b0;
    step();
    chk("mis_no_req", bus.mem_req, 0);

    // Reset during WAIT, then a late response.
    M_Ctrl_in     = 5'b01101;
    addr_in       = 64'h7000;
    bus.mem_rdata = 64'hCAFE_F00D_1234_5678;
    bus.mem_gnt   = 1'b1;
    step();                 // REQ
    step();                 // WAIT 1
    bus.mem_gnt = 1'b0;
    step();                 // WAIT 2
    rst       = 1'b1;
    M_Ctrl_in = 5'b0;
    #2;
    chk("rstw_req",   bus.mem_req, 0);
    chk("rstw_stall", stall,       0);
    chk("rstw_regs",  {bus.mem_we, bus.mem_wstrb, bus.mem_addr}, 0);
    chk("rstw_data",  load_data,   0);
    step();
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_gnt    = 1'b1;
    @(negedge clk);
    chk("late_rv_0", {load_valid, bus_err, stall}, 3'b000);
    step();
    @(negedge clk);
    chk("late_rv_1", {load_valid, bus_err, bus.mem_req}, 3'b000);
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b0;
    access("ld_post", 5'b01101, 64'h7010, 64'h0, 64'h0BAD_BEEF_0000_0042, 1, 1, 3,
           64'h7010, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h0BAD_BEEF_0000_0042, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
